// File: rtl/usb_crc_serial_engine.sv
// Serial USB CRC generator/checker: CRC5 for tokens or CRC16 for data, chosen by parameter.
// In transmit it passes payload bits through and then appends the inverted CRC; in receive it checks the residual.
module usb_crc_serial_engine #(
  parameter int unsigned      CRC_W    = 5,
  parameter logic [CRC_W-1:0] POLY     = CRC_W'(5'h05),
  parameter logic [CRC_W-1:0] INIT     = '1,
  parameter logic [CRC_W-1:0] RESIDUAL = CRC_W'(5'h0C)
) (
  input  logic             clk_c,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic             halt_tx,
  input  logic             bit_valid,
  input  logic             bit_last,
  input  logic             data_in,
  output logic             data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             crc_done,
  output logic             error,
  output logic             err_sticky,
  output logic [CRC_W-1:0] crc_value
);
  // state  | meaning
  // IDLE   | no packet, waiting for start
  // DATA   | consuming payload bits (tx: pass-through, rx: includes CRC bits)
  // APPEND | tx only, shifting out inverted CRC MSB-first, cnt_q counts down
  // CHECK  | rx only, single cycle residual compare
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_APPEND, S_CHECK} state_t;

  localparam int unsigned CNT_W = $clog2(CRC_W);

  state_t           state;
  logic [CRC_W-1:0] crc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic             sticky_q;
  logic             consume;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic d);
    crc_step = {c[CRC_W-2:0], 1'b0} ^ ((d ^ c[CRC_W-1]) ? POLY : '0);
  endfunction

  assign consume = (state == S_DATA) && bit_valid && !halt_tx;

  always_ff @(posedge clk_c or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      crc_q    <= INIT;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else if (start) begin
      // start wins over halt and silently abandons any packet in flight
      state    <= S_DATA;
      crc_q    <= INIT;
      cnt_q    <= '0;
      mode_q   <= mode;
      sticky_q <= 1'b0;
    end else begin
      case (state)
        S_DATA: begin
          if (consume) begin
            crc_q <= crc_step(crc_q, data_in);
            if (bit_last) begin
              if (mode_q) begin
                state <= S_CHECK;
              end else begin
                state <= S_APPEND;
                cnt_q <= CNT_W'(CRC_W - 1);
              end
            end
          end
        end
        S_APPEND: begin
          if (!halt_tx) begin
            crc_q <= {crc_q[CRC_W-2:0], 1'b0};
            if (cnt_q == '0) state <= S_IDLE;
            else             cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CHECK: begin
          if (crc_q != RESIDUAL) sticky_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; a start in the same cycle suppresses
  // any bit, done or error belonging to the packet it aborts.
  always_comb begin
    data_out  = 1'b0;
    out_valid = 1'b0;
    crc_done  = 1'b0;
    error     = 1'b0;
    if (!start) begin
      case (state)
        S_DATA: begin
          if (!mode_q) begin
            data_out  = data_in;
            out_valid = bit_valid && !halt_tx;
          end
        end
        S_APPEND: begin
          data_out  = ~crc_q[CRC_W-1];
          out_valid = !halt_tx;
          crc_done  = !halt_tx && (cnt_q == '0);
        end
        S_CHECK: begin
          crc_done = 1'b1;
          error    = (crc_q != RESIDUAL);
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign err_sticky = sticky_q | error;
  assign crc_value  = crc_q;

endmodule

// File: tb/tb_usb_crc_serial_engine.sv
// Bench for usb_crc_serial_engine: CRC5 and CRC16 instances share one stimulus stream and are
// compared every cycle against a polynomial-division reference model, plus literal spot values.
module tb_usb_crc_serial_engine;
  logic clk_c = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0, mode = 1'b0, halt_tx = 1'b0, bit_valid = 1'b0, bit_last = 1'b0, data_in = 1'b0;

  logic do5, ov5, busy5, done5, err5, stk5;
  logic [4:0] crc5;
  logic do16, ov16, busy16, done16, err16, stk16;
  logic [15:0] crc16;

  int checks = 0;
  int failures = 0;

  always #5 clk_c = ~clk_c;

  usb_crc_serial_engine #(.CRC_W(5)) u_crc5 (
    .clk_c(clk_c), .reset_n(reset_n), .start(start), .mode(mode), .halt_tx(halt_tx),
    .bit_valid(bit_valid), .bit_last(bit_last), .data_in(data_in),
    .data_out(do5), .out_valid(ov5), .busy(busy5), .crc_done(done5), .error(err5),
    .err_sticky(stk5), .crc_value(crc5));

  usb_crc_serial_engine #(.CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUAL(16'h800D)) u_crc16 (
    .clk_c(clk_c), .reset_n(reset_n), .start(start), .mode(mode), .halt_tx(halt_tx),
    .bit_valid(bit_valid), .bit_last(bit_last), .data_in(data_in),
    .data_out(do16), .out_valid(ov16), .busy(busy16), .crc_done(done16), .error(err16),
    .err_sticky(stk16), .crc_value(crc16));

  logic        a_do[2], a_ov[2], a_busy[2], a_done[2], a_err[2], a_stk[2];
  logic [15:0] a_crc[2];
  always_comb begin
    a_do[0] = do5;   a_ov[0] = ov5;   a_busy[0] = busy5;   a_done[0] = done5;
    a_err[0] = err5; a_stk[0] = stk5; a_crc[0] = {11'b0, crc5};
    a_do[1] = do16;  a_ov[1] = ov16;  a_busy[1] = busy16;  a_done[1] = done16;
    a_err[1] = err16; a_stk[1] = stk16; a_crc[1] = crc16;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          mw[2]    = '{5, 16};
  logic [15:0] mpoly[2] = '{16'h0005, 16'h8005};
  logic [15:0] minit[2] = '{16'h001F, 16'hFFFF};
  logic [15:0] mres[2]  = '{16'h000C, 16'h800D};
  logic [15:0] mmask[2] = '{16'h001F, 16'hFFFF};

  int          m_ph[2];   // 0 idle, 1 data, 2 append, 3 check
  logic        m_mode[2];
  logic [15:0] m_crc[2];
  logic        m_stk[2];
  bit          app_q[2][$];
  logic [127:0] msg;
  int          nb;

  // Register contents = (INIT * x^n + M(x) * x^W) mod G, first wire bit is the highest degree of M.
  function automatic logic [15:0] crc_of(input int i);
    logic [127:0] r, g;
    int w;
    w = mw[i];
    r = {112'b0, minit[i]} << nb;
    for (int k = 0; k < nb; k++) if (msg[k]) r[nb - 1 - k + w] = ~r[nb - 1 - k + w];
    g = {112'b0, mpoly[i]} | (128'b1 << w);
    for (int d = nb + w - 1; d >= w; d--) if (r[d]) r = r ^ (g << (d - w));
    return r[15:0];
  endfunction

  initial forever begin
    @(posedge clk_c or negedge reset_n);
    if (!reset_n) begin
      nb = 0; msg = '0;
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = 0; m_mode[i] = 1'b0; m_crc[i] = minit[i]; m_stk[i] = 1'b0; app_q[i].delete();
      end
    end else if (start) begin
      nb = 0; msg = '0;
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = 1; m_mode[i] = mode; m_crc[i] = minit[i]; m_stk[i] = 1'b0; app_q[i].delete();
      end
    end else begin
      if (m_ph[0] == 1 && bit_valid && !halt_tx) begin
        msg[nb] = data_in;
        nb++;
      end
      for (int i = 0; i < 2; i++) begin
        case (m_ph[i])
          1: if (bit_valid && !halt_tx) begin
               m_crc[i] = crc_of(i);
               if (bit_last) begin
                 if (m_mode[i]) m_ph[i] = 3;
                 else begin
                   m_ph[i] = 2;
                   for (int b = mw[i] - 1; b >= 0; b--) app_q[i].push_back(~m_crc[i][b]);
                 end
               end
             end
          2: if (!halt_tx) begin
               void'(app_q[i].pop_front());
               m_crc[i] = (m_crc[i] << 1) & mmask[i];
               if (app_q[i].size() == 0) m_ph[i] = 0;
             end
          3: begin
               if (m_crc[i] != mres[i]) m_stk[i] = 1'b1;
               m_ph[i] = 0;
             end
          default: ;
        endcase
      end
    end
  end

  logic e_ov, e_do, e_done, e_err, c_do;
  initial forever begin
    @(negedge clk_c);
    for (int i = 0; i < 2; i++) begin
      e_ov = 1'b0; e_do = 1'b0; e_done = 1'b0; e_err = 1'b0; c_do = 1'b1;
      if (!start) begin
        case (m_ph[i])
          1: if (!m_mode[i]) begin
               e_ov = bit_valid & ~halt_tx; e_do = data_in; c_do = e_ov;
             end
          2: begin
               e_ov = ~halt_tx; c_do = ~halt_tx;
               if (!halt_tx) begin
                 e_do = app_q[i][0];
                 e_done = (app_q[i].size() == 1);
               end
             end
          3: begin
               e_done = 1'b1; e_err = (m_crc[i] != mres[i]);
             end
          default: ;
        endcase
      end
      chk($sformatf("busy_w%0d", mw[i]), a_busy[i], (m_ph[i] != 0));
      chk($sformatf("crc_value_w%0d", mw[i]), a_crc[i], m_crc[i]);
      chk($sformatf("out_valid_w%0d", mw[i]), a_ov[i], e_ov);
      chk($sformatf("crc_done_w%0d", mw[i]), a_done[i], e_done);
      chk($sformatf("error_w%0d", mw[i]), a_err[i], e_err);
      chk($sformatf("err_sticky_w%0d", mw[i]), a_stk[i], m_stk[i] | e_err);
      if (c_do) chk($sformatf("data_out_w%0d", mw[i]), a_do[i], e_do);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic st, input logic md, input logic h, input logic v, input logic l, input logic d);
    @(posedge clk_c); #1;
    start = st; mode = md; halt_tx = h; bit_valid = v; bit_last = l; data_in = d;
  endtask

  task automatic idle1();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_pkt(input logic md);
    cyc(1'b1, md, 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic d, input logic l);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, l, d);
  endtask

  task automatic feed_bits(input int len, input int ph, input int pg);
    int idx;
    int guard;
    logic h, v;
    idx = 0; guard = 0;
    while (idx < len && guard < 2000) begin
      h = ($urandom_range(99) < ph);
      v = ($urandom_range(99) >= pg);
      cyc(1'b0, 1'b0, h, v, (idx == len - 1), 1'($urandom_range(1)));
      if (v && !h) idx++;
      guard++;
    end
  endtask

  task automatic drain(input int ph);
    int n;
    n = 0;
    while ((busy5 || busy16) && n < 300) begin
      cyc(1'b0, 1'b0, ($urandom_range(99) < ph), 1'($urandom_range(1)),
          1'($urandom_range(1)), 1'($urandom_range(1)));
      n++;
    end
    chk("drain_bound", (n < 300), 1'b1);
    idle1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  bits5, dn5;
    logic [15:0] v16;
    int n5, n16, viol;
    logic [15:0] tok;

    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk_c);
    #2 reset_n = 1'b1;
    #1;
    chk("rst_crc5", crc5, 5'h1F);
    chk("rst_crc16", crc16, 16'hFFFF);
    chk("rst_busy", busy5 | busy16, 1'b0);

    // CRC5 tx of an all-zero token body (addr 0 / endp 0)
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) bit_in(1'b0, (i == 10));
    bits5 = '0; dn5 = '0; n5 = 0;
    for (int k = 0; k < 5; k++) begin
      idle1(); #1;
      if (k == 0) chk("tx5_crc_after_data", crc5, 5'b10111);
      bits5 = {bits5[3:0], do5};
      dn5 = {dn5[3:0], done5};
      if (ov5) n5++;
    end
    chk("tx5_append_bits", bits5, 5'b01000);
    chk("tx5_done_on_5th", dn5, 5'b00001);
    chk("tx5_valid_count", n5, 5);
    drain(0);

    // CRC5 rx, good token
    tok = 16'b0000_0000_0000_1000;   // bits sent from index 15 down: 11 zeros then 0,1,0,0,0
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int b = 15; b >= 0; b--) bit_in(tok[b], (b == 0));
    idle1(); #1;
    chk("rx5_residual", crc5, 5'h0C);
    chk("rx5_done", done5, 1'b1);
    chk("rx5_no_error", err5, 1'b0);
    drain(0);

    // CRC5 rx with the 7th bit flipped
    tok[9] = ~tok[9];
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int b = 15; b >= 0; b--) bit_in(tok[b], (b == 0));
    idle1(); #1;
    chk("rx5_bad_error", err5, 1'b1);
    chk("rx5_bad_sticky", stk5, 1'b1);
    repeat (3) idle1();
    #1 chk("rx5_sticky_held", stk5, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle1(); #1;
    chk("rx5_sticky_cleared", stk5, 1'b0);
    feed_bits(3, 0, 0);
    drain(0);

    // CRC16 tx with a single payload bit and alternating halt during append
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b1);
    n16 = 0; viol = 0; v16 = '0;
    for (int k = 0; k < 60 && (busy5 || busy16); k++) begin
      cyc(1'b0, 1'b0, k[0], 1'b0, 1'b0, 1'b0); #1;
      if (ov16) begin
        n16++;
        v16 = {v16[14:0], do16};
        if (halt_tx) viol++;
      end
    end
    chk("tx16_append_count", n16, 16);
    chk("tx16_no_bit_in_halt", viol, 0);
    idle1();

    // loop the CRC16 packet back through receive
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0);
    for (int b = 15; b >= 0; b--) bit_in(v16[b], (b == 0));
    idle1(); #1;
    chk("rx16_residual", crc16, 16'h800D);
    chk("rx16_no_error", err16, 1'b0);
    drain(0);

    // halt held in DATA with bit_valid high
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bit_in(1'($urandom_range(1)), 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'($urandom_range(1)));
    for (int i = 0; i < 5; i++) bit_in(1'($urandom_range(1)), (i == 4));
    drain(0);

    // abort mid-append
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    feed_bits(8, 0, 0);
    idle1(); idle1();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle1(); #1;
    chk("abort_crc5_init", crc5, 5'h1F);
    chk("abort_crc16_init", crc16, 16'hFFFF);
    chk("abort_busy", busy5 & busy16, 1'b1);
    feed_bits(10, 10, 10);
    drain(20);

    // asynchronous reset pulse mid-DATA
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
    @(posedge clk_c);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy5 | busy16, 1'b0);
    chk("arst_out_valid", ov5 | ov16, 1'b0);
    chk("arst_data_out", do5 | do16, 1'b0);
    chk("arst_crc5", crc5, 5'h1F);
    chk("arst_crc16", crc16, 16'hFFFF);
    #3 reset_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("arst_stays_idle", busy5 | busy16, 1'b0);
    idle1();

    // randomized packets
    for (int p = 0; p < 40; p++) begin
      start_pkt(1'($urandom_range(1)));
      feed_bits($urandom_range(1, 40), $urandom_range(0, 40), $urandom_range(0, 40));
      if ($urandom_range(5) == 0) begin
        repeat ($urandom_range(0, 6)) cyc(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
        start_pkt(1'($urandom_range(1)));
        feed_bits($urandom_range(1, 40), $urandom_range(0, 40), $urandom_range(0, 40));
      end
      drain($urandom_range(0, 50));
    end

    repeat (2) idle1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
